// File: rtl/wide_to_narrow_sched_pkg.sv
// Shared types for the wide-to-narrow scheduler.
package wide_to_narrow_sched_pkg;

    // XSTATE is the unused encoding; the FSM falls back to IDLE from it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        DRAIN  = 2'd2,
        XSTATE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/wide_to_narrow.sv
// One-line buffer that serialises a wide line into narrow beats,
// highest element first, trimming zero-keep tail elements of the last line.
module wide_to_narrow #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int ELS    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_val,
    input  logic [ELS*DATA_W-1:0]  i_data,
    input  logic [ELS*KEEP_W-1:0]  i_keep,
    input  logic                   i_last,
    output logic                   o_rdy,
    output logic                   o_val,
    output logic [DATA_W-1:0]      o_data,
    output logic [KEEP_W-1:0]      o_keep,
    output logic                   o_last,
    input  logic                   i_rdy
);
    localparam int IDX_W = $clog2(ELS);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ELS - 1);

    logic                   r_full;
    logic                   r_last;
    logic [IDX_W-1:0]       r_idx;
    logic [ELS*DATA_W-1:0]  r_data;
    logic [ELS*KEEP_W-1:0]  r_keep;

    logic w_lower_nz;
    logic w_beat_last;
    logic w_line_done;
    logic w_in_hs;
    logic w_out_hs;

    always_comb begin
        w_lower_nz = 1'b0;
        for (int j = 0; j < ELS; j++) begin
            if ((IDX_W'(j) < r_idx) && (|r_keep[j*KEEP_W +: KEEP_W])) begin
                w_lower_nz = 1'b1;
            end
        end
    end

    assign w_beat_last = r_last & ~w_lower_nz;
    assign w_line_done = (r_idx == '0) | w_beat_last;

    assign o_val  = r_full;
    assign o_data = r_data[r_idx*DATA_W +: DATA_W];
    assign o_keep = r_keep[r_idx*KEEP_W +: KEEP_W];
    assign o_last = r_full & w_beat_last;

    // A new line may load in the same cycle the current one finishes.
    assign o_rdy    = ~r_full | (i_rdy & w_line_done);
    assign w_in_hs  = i_val & o_rdy;
    assign w_out_hs = r_full & i_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_last <= 1'b0;
            r_idx  <= '0;
        end else if (w_in_hs) begin
            r_full <= 1'b1;
            r_last <= i_last;
            r_idx  <= TOP_IDX;
        end else if (w_out_hs) begin
            if (w_line_done) begin
                r_full <= 1'b0;
            end else begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_data <= i_data;
            r_keep <= i_keep;
        end
    end

endmodule

// File: rtl/wide_to_narrow_sched.sv
// Packet-granular round-robin scheduler feeding one wide-to-narrow converter.
module wide_to_narrow_sched #(
    parameter int NUM_SRCS    = 4,
    parameter int OUT_DATA_W  = 64,
    parameter int OUT_KEEP_W  = OUT_DATA_W / 8,
    parameter int IN_DATA_ELS = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_SRCS-1:0]                        src_sched_val,
    input  logic [NUM_SRCS*IN_DATA_ELS*OUT_DATA_W-1:0] src_sched_data,
    input  logic [NUM_SRCS*IN_DATA_ELS*OUT_KEEP_W-1:0] src_sched_keep,
    input  logic [NUM_SRCS-1:0]                        src_sched_last,
    output logic [NUM_SRCS-1:0]                        sched_src_rdy,
    input  logic [NUM_SRCS-1:0]                        src_en_mask,
    output logic                                       sched_dst_val,
    output logic [OUT_DATA_W-1:0]                      sched_dst_data,
    output logic [OUT_KEEP_W-1:0]                      sched_dst_keep,
    output logic                                       sched_dst_last,
    input  logic                                       dst_sched_rdy,
    output logic [$clog2(NUM_SRCS)-1:0]                sched_dst_src_id,
    output logic                                       sched_busy
);
    import wide_to_narrow_sched_pkg::*;

    localparam int SRC_ID_W = $clog2(NUM_SRCS);
    localparam int LINE_W   = IN_DATA_ELS * OUT_DATA_W;
    localparam int LKEEP_W  = IN_DATA_ELS * OUT_KEEP_W;
    localparam logic [SRC_ID_W-1:0] LAST_SRC = SRC_ID_W'(NUM_SRCS - 1);

    sched_state_e         r_state;
    sched_state_e         w_next;
    logic [SRC_ID_W-1:0]  r_grant;
    logic [SRC_ID_W-1:0]  r_ptr;
    logic [SRC_ID_W-1:0]  w_winner;
    logic [NUM_SRCS-1:0]  w_elig;
    logic                 w_any;
    logic                 w_conv_val;
    logic                 w_conv_rdy;
    logic                 w_conv_last;
    logic [LINE_W-1:0]    w_conv_data;
    logic [LKEEP_W-1:0]   w_conv_keep;
    logic                 w_final_hs;

    // Lowest offset from ptr wins, so scan offsets high-to-low.
    function automatic logic [SRC_ID_W-1:0] rr_pick(
        input logic [NUM_SRCS-1:0] req,
        input logic [SRC_ID_W-1:0] ptr
    );
        logic [SRC_ID_W-1:0] pick;
        int j;
        pick = ptr;
        for (int k = NUM_SRCS - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_SRCS;
            if (req[j]) pick = SRC_ID_W'(j);
        end
        return pick;
    endfunction

    assign w_elig   = src_sched_val & src_en_mask;
    assign w_any    = |w_elig;
    assign w_winner = rr_pick(w_elig, r_ptr);

    assign w_conv_val  = (r_state == FEED) & src_sched_val[r_grant];
    assign w_conv_last = src_sched_last[r_grant];
    assign w_conv_data = src_sched_data[r_grant*LINE_W +: LINE_W];
    assign w_conv_keep = src_sched_keep[r_grant*LKEEP_W +: LKEEP_W];

    assign w_final_hs = sched_dst_val & dst_sched_rdy & sched_dst_last;

    always_comb begin
        sched_src_rdy = '0;
        if (r_state == FEED) sched_src_rdy[r_grant] = w_conv_rdy;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = FEED;
            FEED:    if (w_conv_val && w_conv_rdy && w_conv_last) w_next = DRAIN;
            DRAIN:   if (w_final_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) r_grant <= w_winner;
            if (r_state == DRAIN && w_final_hs) begin
                r_ptr <= (r_grant == LAST_SRC) ? '0 : r_grant + 1'b1;
            end
        end
    end

    assign sched_busy       = (r_state != IDLE);
    assign sched_dst_src_id = r_grant;

    wide_to_narrow #(
        .DATA_W (OUT_DATA_W),
        .KEEP_W (OUT_KEEP_W),
        .ELS    (IN_DATA_ELS)
    ) u_w2n (
        .clk    (clk),
        .rst    (rst),
        .i_val  (w_conv_val),
        .i_data (w_conv_data),
        .i_keep (w_conv_keep),
        .i_last (w_conv_last),
        .o_rdy  (w_conv_rdy),
        .o_val  (sched_dst_val),
        .o_data (sched_dst_data),
        .o_keep (sched_dst_keep),
        .o_last (sched_dst_last),
        .i_rdy  (dst_sched_rdy)
    );

endmodule

// File: doc/wide_to_narrow_sched.md
WIDE_TO_NARROW_SCHED -- requirements
Module: wide_to_narrow_sched

Interface
REQ-001 Parameter NUM_SRCS, default 4, number of wide requesters; SHALL be >= 2.
REQ-002 Parameter OUT_DATA_W, default 64, narrow data width in bits.
REQ-003 Parameter OUT_KEEP_W, default OUT_DATA_W/8, narrow keep width.
REQ-004 Parameter IN_DATA_ELS, default 4, narrow elements per wide line; SHALL be >= 2.
REQ-005 Localparam SRC_ID_W = $clog2(NUM_SRCS).
REQ-006 clk  input  1  sole clock; all logic rising-edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 src_sched_val  input  NUM_SRCS  per-source wide-line valid.
REQ-009 src_sched_data  input  NUM_SRCS x IN_DATA_ELS x OUT_DATA_W  per-source wide data; element IN_DATA_ELS-1 is emitted first.
REQ-010 src_sched_keep  input  NUM_SRCS x IN_DATA_ELS x OUT_KEEP_W  per-source keep.
REQ-011 src_sched_last  input  NUM_SRCS  per-source last-line-of-packet flag.
REQ-012 sched_src_rdy  output  NUM_SRCS  per-source ready; at most one bit set per cycle.
REQ-013 src_en_mask  input  NUM_SRCS  arbitration enable per source, sampled only in IDLE.
REQ-014 sched_dst_val / sched_dst_data / sched_dst_keep / sched_dst_last  output  1 / OUT_DATA_W / OUT_KEEP_W / 1  narrow stream.
REQ-015 dst_sched_rdy  input  1  narrow-stream ready.
REQ-016 sched_dst_src_id  output  SRC_ID_W  source index of the current narrow beat; valid whenever sched_dst_val=1.
REQ-017 sched_busy  output  1  high in any state other than IDLE.

Function
REQ-018 Handshake on every stream SHALL be val&rdy in the same cycle; valid/payload SHALL NOT depend on the receiver's rdy.
REQ-019 Arbitration SHALL be packet-granular round-robin among sources with val=1 and src_en_mask=1, searching upward from rr_ptr and wrapping at NUM_SRCS-1 -> 0.
REQ-020 FSM states: IDLE, FEED, DRAIN.
REQ-021 IDLE: no rdy asserted; if any eligible request, grant_reg <= winner and go to FEED next cycle; otherwise stay in IDLE.
REQ-022 FEED: source grant_reg is muxed to the converter input; sched_src_rdy[grant_reg] = converter ready; all other rdy bits = 0.
REQ-023 FEED: on acceptance of a line with last=1, go to DRAIN; otherwise stay in FEED, including while the granted source deasserts val mid-packet (grant held).
REQ-024 DRAIN: all sched_src_rdy = 0; on narrow handshake with sched_dst_last=1, set rr_ptr <= grant_reg+1 (wrapping) and go to IDLE.
REQ-025 Narrow packet boundary: the last narrow beat is the final element with nonzero keep in the last line; elements after it are not emitted.
REQ-026 Latency: request in IDLE at cycle t -> granted source rdy at t+1 -> first narrow beat valid at t+2.
REQ-027 Minimum gap between packets: one IDLE cycle after the final narrow handshake.
REQ-028 Changing src_en_mask while in FEED or DRAIN SHALL NOT abort the current packet.
REQ-029 sched_dst_src_id SHALL equal grant_reg; grant_reg is stable from FEED entry until return to IDLE.

Reset
REQ-030 On rst: state = IDLE, rr_ptr = 0, grant_reg = 0, the converter is reset.
REQ-031 Outputs during and after reset, until the first grant: sched_src_rdy = 0, sched_dst_val = 0, sched_dst_last = 0, sched_busy = 0, sched_dst_src_id = 0.
REQ-032 Reset mid-packet SHALL discard the partial packet with no further narrow beats; sources SHALL resend.

Structure
REQ-033 Package wide_to_narrow_sched_pkg holds the state enum (IDLE, FEED, DRAIN, plus X default).
REQ-034 The block SHALL instantiate exactly one wide_to_narrow as its datapath sub-module; arbitration and muxing are local logic.
REQ-035 The round-robin winner SHALL be a combinational function of request, mask and rr_ptr.

Verification (NUM_SRCS=4, OUT_DATA_W=64, IN_DATA_ELS=4)
REQ-036 Src 2 sends a 2-line packet with all keep = 0xFF -> 8 narrow beats with src_id=2, last only on beat 8, first beat at request+2.
REQ-037 Src 0 sends a 1-line packet with keep elements {3:FF, 2:FF, 1:00, 0:00} -> 2 beats, last on beat 2, then IDLE.
REQ-038 Srcs 0, 1 and 3 request simultaneously with rr_ptr=0 -> packet order 0, 1, 3, 0; no interleaving of beats.
REQ-039 dst_sched_rdy toggles randomly during src 1's 3-line packet -> all 12 beats in order, data held stable while stalled.
REQ-040 src_en_mask = 4'b1011 with src 2 requesting, then mask cleared mid-packet of src 0 -> src 2 is never granted and src 0's packet completes.
REQ-041 rst asserted during FEED of src 3 -> next cycle val=0, busy=0, rdy=0; a subsequent request from src 1 is served from rr_ptr=0.
